// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, prescale floor and vote helper for uart_rx_multi
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } rx_state_e;

  // Smallest oversampling ratio that still leaves room for three mid-bit samples
  localparam logic [5:0] PRESCALE_MIN = 6'd8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_multi_if.sv
// rtl/uart_rx_multi_if.sv - line, configuration and received-word signals of uart_rx_multi
interface uart_rx_multi_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STP2_EN;
  logic [5:0]            Prescale;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  overrun;

  // Side that drives the line and consumes received words
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, STP2_EN, Prescale, rd_en,
    input  P_DATA, data_valid, par_err, stp_err, overrun
  );

  // The receiver itself
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, STP2_EN, Prescale, rd_en,
    output P_DATA, data_valid, par_err, stp_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive FIFO with wrap-bit pointers
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  // Head reads as zero while empty so nothing stale is presented
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_multi.sv
// rtl/uart_rx_multi.sv - UART receiver with majority vote, parity/stop checks; UART_RX_FIFO_EN adds a receive FIFO
module uart_rx_multi
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  uart_rx_multi_if.slave  bus
);

  rx_state_e             state;
  rx_state_e             state_nxt;
  logic                  rx_meta;
  logic                  rx_s;
  logic [5:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stp2_q;
  logic [5:0]            pres_q;
  logic [5:0]            pres_clamped;
  logic [5:0]            mid;
  logic                  samp_a;
  logic                  samp_b;
  logic                  samp_done;
  logic                  edge_wrap;
  logic                  bit_val;
  logic                  last_data;
  logic                  last_stop;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  frame_ok;
  logic                  par_err_q;
  logic                  stp_err_q;

  assign pres_clamped = (bus.Prescale < PRESCALE_MIN) ? PRESCALE_MIN : bus.Prescale;
  assign mid          = {1'b0, pres_q[5:1]};
  assign samp_done    = (edge_cnt == mid + 6'd1);
  assign edge_wrap    = (edge_cnt == pres_q - 6'd1);
  // Third vote is the live sample, so the decision is ready in the samp_done cycle
  assign bit_val      = majority3(samp_a, samp_b, rx_s);
  assign last_data    = (bit_cnt == 4'(DATA_WIDTH - 1));
  assign last_stop    = (bit_cnt == {3'b000, stp2_q});
  assign frame_ok     = (state == DONE) && !par_flag && !stp_flag;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: begin
        if (samp_done && bit_val) state_nxt = IDLE;
        else if (edge_wrap)       state_nxt = DATA;
      end
      DATA:  if (edge_wrap && last_data) state_nxt = par_en_q ? PAR : STOP;
      PAR:   if (edge_wrap) state_nxt = STOP;
      // Leave at the last stop decision so a following start edge is not missed
      STOP:  if (samp_done && last_stop) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Oversampling and bit counters; bit_cnt restarts at every state change
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE || state == DONE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= edge_wrap ? 6'd0 : edge_cnt + 6'd1;
      if (state_nxt != state) bit_cnt <= '0;
      else if (edge_wrap)     bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Frame configuration captured at the start edge so mid-frame changes wait a frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stp2_q    <= 1'b0;
      pres_q    <= PRESCALE_MIN;
    end else if (state == IDLE && !rx_s) begin
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
      stp2_q    <= bus.STP2_EN;
      pres_q    <= pres_clamped;
    end
  end

  // First two votes of each bit, taken just before and at the bit centre
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (edge_cnt == mid - 6'd1) samp_a <= rx_s;
      if (edge_cnt == mid)        samp_b <= rx_s;
    end
  end

  // Data shift (LSB first) and per-frame error flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_sr  <= '0;
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else if (state == IDLE) begin
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else if (samp_done) begin
      case (state)
        DATA: data_sr <= {bit_val, data_sr[DATA_WIDTH-1:1]};
        PAR:  if (bit_val != ((^data_sr) ^ par_typ_q)) par_flag <= 1'b1;
        STOP: if (!bit_val) stp_flag <= 1'b1;
        default: ;
      endcase
    end
  end

  // Error pulses, one cycle after DONE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      par_err_q <= (state == DONE) && par_flag;
      stp_err_q <= (state == DONE) && stp_flag;
    end
  end

  assign bus.par_err = par_err_q;
  assign bus.stp_err = stp_err_q;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_drop;
  logic overrun_q;

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (frame_ok),
    .pop   (bus.rd_en),
    .din   (data_sr),
    .dout  (bus.P_DATA),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Overrun pulse for a clean word that found the FIFO full
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) overrun_q <= 1'b0;
    else      overrun_q <= fifo_drop;
  end

  assign bus.data_valid = !fifo_empty;
  assign bus.overrun    = overrun_q;
`else
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  unused_rd_en;
  localparam int         UNUSED_FIFO_DEPTH = FIFO_DEPTH;

  assign unused_rd_en = bus.rd_en;

  // Output word register and valid pulse; errored frames leave P_DATA untouched
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= frame_ok;
      if (frame_ok) p_data_q <= data_sr;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = 1'b0;
`endif

endmodule
